// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the UART/ALU packet sequencer.
// Contents: header opcodes, ALU operation encoding, controller state
// encoding, the registered ALU request payload and opcode decode helper.
package alu_ctrl_pkg;

  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned OPND_BITS = 32;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;
  localparam logic [7:0] OP_ECHO = 8'hEC;

  typedef enum logic [1:0] {
    ALU_NOP = 2'd0,
    ALU_ADD = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_OPND,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN,
    ST_ECHO
  } ctrl_state_e;

  typedef struct packed {
    alu_op_e              op;
    logic [OPND_BITS-1:0] a;
    logic [OPND_BITS-1:0] b;
  } alu_req_t;

  // Arithmetic opcodes map onto an ALU operation; anything else is ALU_NOP.
  function automatic alu_op_e opcode_to_alu(input logic [7:0] opc);
    case (opc)
      OP_ADD:  return ALU_ADD;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_resp_ser.sv
// Result serializer: loads a DATA_W-bit word and emits it LSB-first as a
// byte stream with valid/ready handshaking.
// Ports: clk, rst_n (async, active-low); load/load_data capture a word;
//        tdata/tvalid/tready byte stream out; done_c pulses on the
//        handshake of the final byte.
module alu_resp_ser #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [7:0]        tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              done_c
);
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              fire;

  assign tdata  = shreg[7:0];
  assign fire   = tvalid && tready;
  assign done_c = fire && (cnt == CNT_W'(NBYTES - 1));

  // Shift one byte out per accepted transfer; tdata holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      tvalid <= 1'b0;
    end else if (load) begin
      shreg  <= load_data;
      cnt    <= '0;
      tvalid <= 1'b1;
    end else if (fire) begin
      shreg <= shreg >> 8;
      cnt   <= cnt + CNT_W'(1);
      if (done_c) tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_packet_ctrl.sv
// Packet sequencer between the UART byte streams and the shared ALU.
// Parses a 4-byte header (opcode, reserved, len lo, len hi), assembles
// little-endian operands, chains them through an accumulator via the ALU
// and returns the 32-bit result LSB-first. Unknown opcodes are drained.
// Build option: ALU_CTRL_ECHO_EN enables opcode 0xEC payload echo
// (combinational rx->tx pass-through); without it 0xEC is drained.
// Ports: clk_i, rst_ni (async, active-low); rx_t* byte stream in;
//        tx_t* byte stream out; alu_* request/result interface;
//        busy_o high while a packet is in progress.
module alu_packet_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPND_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_tdata_i,
  input  logic              rx_tvalid_i,
  output logic              rx_tready_o,
  output logic [7:0]        tx_tdata_o,
  output logic              tx_tvalid_o,
  input  logic              tx_tready_i,
  output logic [1:0]        alu_op_o,
  output logic [OPND_W-1:0] alu_a_o,
  output logic [OPND_W-1:0] alu_b_o,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  input  logic [OPND_W-1:0] alu_res_i,
  input  logic              alu_res_valid_i,
  output logic              busy_o
);
  localparam int unsigned NBYTES = OPND_W / 8;
  localparam int unsigned BCNT_W = $clog2(NBYTES);
  localparam int unsigned HCNT_W = $clog2(HDR_BYTES);

  ctrl_state_e       state_q, state_d;
  logic [HCNT_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [7:0]        opc_q, opc_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  pay_q, pay_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic              first_q, first_d;
  logic [OPND_W-1:0] acc_q, acc_d;
  alu_req_t          req_q, req_d;
  logic              alu_valid_q, alu_valid_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic              busy_q, busy_d;

  logic              rx_fire;
  logic [LEN_W-1:0]  hdr_len;
  logic [LEN_W-1:0]  hdr_pay;
  logic [LEN_W-1:0]  pay_dec;
  logic [OPND_W-1:0] opnd_sh;
  logic              ser_load_c;
  logic              ser_done_c;
  logic [7:0]        ser_tdata;
  logic              ser_tvalid;

  assign rx_fire = rx_tvalid_i && rx_tready_o;
  assign hdr_len = LEN_W'({rx_tdata_i, len_lo_q});
  // Lengths shorter than the header mean an empty payload.
  assign hdr_pay = (hdr_len < LEN_W'(HDR_BYTES)) ? '0 : hdr_len - LEN_W'(HDR_BYTES);
  assign pay_dec = (pay_q != '0) ? pay_q - LEN_W'(1) : pay_q;
  assign opnd_sh = {rx_tdata_i, opnd_q[OPND_W-1:8]};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_HDR;
    else         state_q <= state_d;
  end

  // Next state, datapath next values and serializer load strobe.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    opc_d       = opc_q;
    len_lo_d    = len_lo_q;
    pay_d       = pay_q;
    bcnt_d      = bcnt_q;
    opnd_d      = opnd_q;
    first_d     = first_q;
    acc_d       = acc_q;
    req_d       = req_q;
    alu_valid_d = alu_valid_q;
    ser_load_c  = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (rx_fire) begin
          hdr_cnt_d = hdr_cnt_q + HCNT_W'(1);
          if (hdr_cnt_q == HCNT_W'(0)) begin
            opc_d = rx_tdata_i;
          end else if (hdr_cnt_q == HCNT_W'(2)) begin
            len_lo_d = rx_tdata_i;
          end else if (hdr_cnt_q == HCNT_W'(HDR_BYTES - 1)) begin
            pay_d   = hdr_pay;
            bcnt_d  = '0;
            first_d = 1'b1;
            acc_d   = '0;
            if (opcode_to_alu(opc_q) != ALU_NOP) begin
              // Empty arithmetic payload answers with the cleared accumulator.
              if (hdr_pay == '0) begin
                state_d    = ST_RESP;
                ser_load_c = 1'b1;
              end else begin
                state_d = ST_OPND;
              end
`ifdef ALU_CTRL_ECHO_EN
            end else if (opc_q == OP_ECHO) begin
              state_d = (hdr_pay == '0) ? ST_HDR : ST_ECHO;
`endif
            end else begin
              state_d = (hdr_pay == '0) ? ST_HDR : ST_DRAIN;
            end
          end
        end
      end

      ST_OPND: begin
        if (rx_fire) begin
          opnd_d = opnd_sh;
          pay_d  = pay_dec;
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(NBYTES - 1)) begin
            if (first_q) begin
              state_d = ST_LOAD;
            end else begin
              state_d     = ST_ISSUE;
              req_d.op    = opcode_to_alu(opc_q);
              req_d.a     = acc_q;
              req_d.b     = opnd_sh;
              alu_valid_d = 1'b1;
            end
          end else if (pay_q == LEN_W'(1)) begin
            // Trailing partial operand is discarded.
            state_d    = ST_RESP;
            ser_load_c = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        acc_d   = opnd_q;
        first_d = 1'b0;
        if (pay_q == '0) begin
          state_d    = ST_RESP;
          ser_load_c = 1'b1;
        end else begin
          state_d = ST_OPND;
        end
      end

      ST_ISSUE: begin
        if (alu_ready_i) begin
          alu_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (alu_res_valid_i) begin
          acc_d = alu_res_i;
          if (pay_q == '0) begin
            state_d    = ST_RESP;
            ser_load_c = 1'b1;
          end else begin
            state_d = ST_OPND;
          end
        end
      end

      ST_RESP: begin
        if (ser_done_c) state_d = ST_HDR;
      end

      // Both consume the rest of the payload; ECHO also forwards it.
      ST_DRAIN, ST_ECHO: begin
        if (rx_fire) begin
          pay_d = pay_dec;
          if (pay_q == LEN_W'(1)) state_d = ST_HDR;
        end
      end

      default: state_d = ST_HDR;
    endcase

    rx_rdy_d = (state_d == ST_HDR) || (state_d == ST_OPND) || (state_d == ST_DRAIN);
    busy_d   = !((state_d == ST_HDR) && (hdr_cnt_d == '0));
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hdr_cnt_q   <= '0;
      opc_q       <= '0;
      len_lo_q    <= '0;
      pay_q       <= '0;
      bcnt_q      <= '0;
      opnd_q      <= '0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      req_q       <= '0;
      alu_valid_q <= 1'b0;
      rx_rdy_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      hdr_cnt_q   <= hdr_cnt_d;
      opc_q       <= opc_d;
      len_lo_q    <= len_lo_d;
      pay_q       <= pay_d;
      bcnt_q      <= bcnt_d;
      opnd_q      <= opnd_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      req_q       <= req_d;
      alu_valid_q <= alu_valid_d;
      rx_rdy_q    <= rx_rdy_d;
      busy_q      <= busy_d;
    end
  end

  alu_resp_ser #(
    .DATA_W (OPND_W)
  ) u_resp_ser (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .load      (ser_load_c),
    .load_data (acc_d),
    .tdata     (ser_tdata),
    .tvalid    (ser_tvalid),
    .tready    (tx_tready_i),
    .done_c    (ser_done_c)
  );

  assign alu_op_o    = req_q.op;
  assign alu_a_o     = req_q.a;
  assign alu_b_o     = req_q.b;
  assign alu_valid_o = alu_valid_q;
  assign busy_o      = busy_q;

`ifdef ALU_CTRL_ECHO_EN
  logic echo_act;
  assign echo_act    = (state_q == ST_ECHO);
  assign rx_tready_o = echo_act ? tx_tready_i : rx_rdy_q;
  assign tx_tdata_o  = echo_act ? rx_tdata_i  : ser_tdata;
  assign tx_tvalid_o = echo_act ? rx_tvalid_i : ser_tvalid;
`else
  assign rx_tready_o = rx_rdy_q;
  assign tx_tdata_o  = ser_tdata;
  assign tx_tvalid_o = ser_tvalid;
`endif

endmodule
